// File: rtl/resp_checker_pkg.sv
// Shared types for the response checker: FSM state encoding, index/counter
// widths and a saturating increment helper.
package resp_checker_pkg;

  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/resp_checker_exp_rom.sv
// Expected {x,y} pair lookup: vector i reads EXPECTED[2i+1:2i].
module exp_rom
  import resp_checker_pkg::*;
#(
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [1:0]       pair_o
);

  assign pair_o = EXPECTED[{idx_i, 1'b0} +: 2];

endmodule

// File: rtl/resp_checker.sv
// Response checker: compares NUM_VEC sampled {x,y} pairs against EXPECTED,
// counting mismatches and all-zero samples and recording the first failure.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int          NUM_VEC  = 8,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_x,
  input  logic             in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] zero_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] zero_q;
  logic [IDX_W-1:0] ffi_q;
  logic             ffv_q;

  logic [1:0] exp_pair;
  logic       accept;
  logic       mismatch;

  exp_rom #(.EXPECTED(EXPECTED)) u_exp_rom (
    .idx_i  (idx_q),
    .pair_o (exp_pair)
  );

  assign accept   = in_valid && (state_q == ST_RUN);
  assign mismatch = ({in_x, in_y} != exp_pair);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      zero_q  <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            err_q   <= '0;
            zero_q  <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          // start is ignored here; only accepted samples advance the run
          if (accept) begin
            if (mismatch) begin
              err_q <= sat_inc(err_q);
              if (!ffv_q) begin
                ffv_q <= 1'b1;
                ffi_q <= idx_q;
              end
            end
            if (!in_x && !in_y) zero_q <= sat_inc(zero_q);
            if (idx_q == LAST_IDX) state_q <= ST_DONE;
            else                   idx_q   <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == ST_RUN);
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = (state_q == ST_DONE) && (err_q == '0);
  assign err_count      = err_q;
  assign zero_count     = zero_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: two instances (8 vectors / all-zero expectation and
// 3 vectors / mixed expectation) checked every cycle against a sample-list model.
module tb_resp_checker;

  localparam int          NV  [2] = '{8, 3};
  localparam logic [15:0] EXV [2] = '{16'h0000, 16'h0024};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, in_x = 1'b0, in_y = 1'b0;

  logic [1:0] rdy, bsy, dn, ps, ffv;
  logic [3:0] ec  [2];
  logic [3:0] zc  [2];
  logic [2:0] ffi [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: whether a run was ever started since reset, and the accepted samples
  bit         started [2];
  int         n       [2];
  logic [1:0] smp     [2][8];

  always #5 clk = ~clk;

  resp_checker #(.NUM_VEC(8), .EXPECTED(16'h0000)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .pass(ps[0]), .err_count(ec[0]), .zero_count(zc[0]),
    .first_fail_idx(ffi[0]), .first_fail_vld(ffv[0]));

  resp_checker #(.NUM_VEC(3), .EXPECTED(16'h0024)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .pass(ps[1]), .err_count(ec[1]), .zero_count(zc[1]),
    .first_fail_idx(ffi[1]), .first_fail_vld(ffv[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      started[k] = 1'b0;
      n[k] = 0;
    end
  endfunction

  // Expected outputs derived from the list of samples accepted in this run.
  task automatic model_out(input int k, output int o_rdy, output int o_dn,
                           output int o_ps, output int o_ec, output int o_zc,
                           output int o_ffi, output int o_ffv);
    logic [1:0] e;
    o_ec = 0; o_zc = 0; o_ffi = 0; o_ffv = 0;
    o_rdy = (started[k] && n[k] < NV[k]) ? 1 : 0;
    o_dn  = (started[k] && n[k] == NV[k]) ? 1 : 0;
    for (int i = 0; i < n[k]; i++) begin
      e = 2'(EXV[k] >> (2 * i));
      if (smp[k][i] != e) begin
        if (o_ec < 15) o_ec++;
        if (o_ffv == 0) begin
          o_ffv = 1;
          o_ffi = i;
        end
      end
      if (smp[k][i] == 2'b00 && o_zc < 15) o_zc++;
    end
    o_ps = (o_dn == 1 && o_ec == 0) ? 1 : 0;
  endtask

  task automatic model_step();
    bit running;
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      running = started[k] && n[k] < NV[k];
      if (running && in_valid) begin
        smp[k][n[k]] = {in_x, in_y};
        n[k]++;
      end else if (start && !running) begin
        started[k] = 1'b1;
        n[k] = 0;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit v, input bit x, input bit y);
    start = s; in_valid = v; in_x = x; in_y = y;
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    int r, d, p, e, z, fi, fv;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        model_out(k, r, d, p, e, z, fi, fv);
        chk($sformatf("in_ready[%0d]", k), int'(rdy[k]), r);
        chk($sformatf("busy[%0d]", k), int'(bsy[k]), r);
        chk($sformatf("done[%0d]", k), int'(dn[k]), d);
        chk($sformatf("pass[%0d]", k), int'(ps[k]), p);
        chk($sformatf("err_count[%0d]", k), int'(ec[k]), e);
        chk($sformatf("zero_count[%0d]", k), int'(zc[k]), z);
        chk($sformatf("first_fail_idx[%0d]", k), int'(ffi[k]), fi);
        chk($sformatf("first_fail_vld[%0d]", k), int'(ffv[k]), fv);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rdy"}, int'(rdy[k]), 0);
      chk({tag, "_busy"}, int'(bsy[k]), 0);
      chk({tag, "_done"}, int'(dn[k]), 0);
      chk({tag, "_pass"}, int'(ps[k]), 0);
      chk({tag, "_ec"}, int'(ec[k]), 0);
      chk({tag, "_zc"}, int'(zc[k]), 0);
      chk({tag, "_ffi"}, int'(ffi[k]), 0);
      chk({tag, "_ffv"}, int'(ffv[k]), 0);
    end
  endtask

  initial begin
    model_clear();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // all-zero run
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
    chk("allzero_done", int'(dn[0]), 1);
    chk("allzero_pass", int'(ps[0]), 1);
    chk("allzero_ec", int'(ec[0]), 0);
    chk("allzero_zc", int'(zc[0]), 8);
    chk("allzero_ffv", int'(ffv[0]), 0);
    chk("nv3_done", int'(dn[1]), 1);
    chk("nv3_ec", int'(ec[1]), 2);
    chk("nv3_ffi", int'(ffi[1]), 1);
    chk("nv3_zc", int'(zc[1]), 3);
    chk("nv3_pass", int'(ps[1]), 0);

    // vectors 3 and 6 return {1,0}
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, (i == 3 || i == 6), 0);
    chk("err36_ec", int'(ec[0]), 2);
    chk("err36_ffi", int'(ffi[0]), 3);
    chk("err36_ffv", int'(ffv[0]), 1);
    chk("err36_pass", int'(ps[0]), 0);
    chk("err36_zc", int'(zc[0]), 6);

    // in_valid every other cycle, then extra samples after completion
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, i[0], 1'($urandom), 1'($urandom));
    chk("alt_done", int'(dn[0]), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("alt_ready_after", int'(rdy[0]), 0);

    // start mid-run at idx=4 (alone and coinciding with a sample)
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, (i == 1), 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("midstart_done", int'(dn[0]), 1);
    chk("midstart_ec", int'(ec[0]), 1);
    chk("midstart_zc", int'(zc[0]), 7);
    chk("midstart_ffi", int'(ffi[0]), 1);

    // restart from DONE clears results
    cyc(1, 0, 0, 0);
    chk("restart_busy", int'(bsy[0]), 1);
    chk("restart_ec", int'(ec[0]), 0);
    chk("restart_zc", int'(zc[0]), 0);
    chk("restart_ffv", int'(ffv[0]), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, (i == 7));
    chk("restart_ffi", int'(ffi[0]), 7);

    // asynchronous reset at idx=5
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_all_zero("async_rst");
    cyc(0, 1, 0, 0);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0);
    chk("post_rst_busy", int'(bsy[0]), 0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_all_zero("rand_rst");
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
      end
      cyc($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0);
    end

    cyc(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
